// File: rtl/dmem_lsu_ram.sv
// dmem_lsu_ram: RISC-V load/store data RAM with lane decode, load extension and a read-only snoop port
module dmem_lsu_ram #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 13,
  parameter int OUT_REG     = 0,
  parameter int WRITE_FIRST = 0
) (
  input  logic                                 clka,
  input  logic                                 rsta,
  input  logic                                 a_valid,
  input  logic                                 a_we,
  input  logic [2:0]                           a_size,
  input  logic [ADDR_W-1:0]                    a_addr,
  input  logic [DATA_W-1:0]                    a_wdata,
  output logic                                 a_rsp_valid,
  output logic [DATA_W-1:0]                    a_rdata,
  output logic                                 a_fault,
  input  logic                                 b_valid,
  input  logic [ADDR_W-$clog2(DATA_W/8)-1:0]   b_addr,
  output logic                                 b_rsp_valid,
  output logic [DATA_W-1:0]                    b_rdata
);
  localparam int BE_W = DATA_W / 8;
  localparam int OW   = $clog2(BE_W);
  localparam int IW   = ADDR_W - OW;
  logic [DATA_W-1:0] mem [2**IW];
  logic [OW-1:0]     off;
  logic [IW-1:0]     idx;
  logic              ok;
  logic [BE_W-1:0]   bm, en;
  logic [DATA_W-1:0] wrep, mrg, sh, m, rd_d;
  logic              sg;
  logic              v1_q, z1_q, f1_q, bv1_q, v2_q, af2_q, bv2_q;
  logic [2:0]        sz1_q;
  logic [OW-1:0]     off1_q;
  logic [DATA_W-1:0] aw1_q, bw1_q, ar2_q, br2_q;
  assign off = a_addr[OW-1:0];
  assign idx = a_addr[ADDR_W-1:OW];
  always_comb begin
    ok = a_size[1:0] == 2'b00 ? 1'b1 :
         a_size[1:0] == 2'b01 ? ~off[0] :
         a_size == 3'b010 ? off[1:0] == 2'b00 :
         a_size == 3'b110 ? (DATA_W == 64 && off[1:0] == 2'b00) :
         a_size == 3'b011 ? (DATA_W == 64 && off == '0) : 1'b0;
    bm = ~({BE_W{1'b1}} << (4'd1 << a_size[1:0]));
    en = (a_valid & a_we & ok) ? bm << off : '0;
    wrep = '0;
    mrg = '0;
    for (int i = 0; i < BE_W; i++) begin
      wrep[8*i+:8] = a_wdata[8*(i & ((1 << a_size[1:0]) - 1))+:8];
      mrg[8*i+:8]  = en[i] ? wrep[8*i+:8] : mem[b_addr][8*i+:8];
    end
  end
  always_ff @(posedge clka)
    for (int i = 0; i < BE_W; i++)
      if (en[i]) mem[idx][8*i+:8] <= wrep[8*i+:8];
  // m covers the loaded field; its top bit selects the sign source
  always_comb begin
    sh   = aw1_q >> {off1_q, 3'b000};
    m    = ~({DATA_W{1'b1}} << (7'd8 << sz1_q[1:0]));
    sg   = ~sz1_q[2] & |(sh & m & ~(m >> 1));
    rd_d = z1_q ? '0 : (sh & m) | ({DATA_W{sg}} & ~m);
  end
  always_ff @(posedge clka or posedge rsta)
    if (rsta) begin
      v1_q   <= 1'b0;
      z1_q   <= 1'b0;
      f1_q   <= 1'b0;
      sz1_q  <= '0;
      off1_q <= '0;
      aw1_q  <= '0;
      bv1_q  <= 1'b0;
      bw1_q  <= '0;
      v2_q   <= 1'b0;
      af2_q  <= 1'b0;
      ar2_q  <= '0;
      bv2_q  <= 1'b0;
      br2_q  <= '0;
    end else begin
      v1_q  <= a_valid;
      bv1_q <= b_valid;
      if (a_valid) begin
        z1_q   <= a_we | ~ok;
        f1_q   <= ~ok;
        sz1_q  <= a_size;
        off1_q <= off;
        aw1_q  <= mem[idx];
      end
      if (b_valid) bw1_q <= (WRITE_FIRST != 0 && idx == b_addr) ? mrg : mem[b_addr];
      v2_q  <= v1_q;
      af2_q <= v1_q & f1_q;
      bv2_q <= bv1_q;
      if (v1_q) ar2_q <= rd_d;
      if (bv1_q) br2_q <= bw1_q;
    end
  assign a_rsp_valid = OUT_REG != 0 ? v2_q  : v1_q;
  assign a_rdata     = OUT_REG != 0 ? ar2_q : rd_d;
  assign a_fault     = OUT_REG != 0 ? af2_q : v1_q & f1_q;
  assign b_rsp_valid = OUT_REG != 0 ? bv2_q : bv1_q;
  assign b_rdata     = OUT_REG != 0 ? br2_q : bw1_q;
endmodule

// File: tb/tb_dmem_lsu_ram.sv
// tb_dmem_lsu_ram: directed checks of three configurations (32b/lat1/read-old, 32b/lat2/write-first, 64b/lat1)
module tb_dmem_lsu_ram;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic av = 0, awe = 0, bv = 0;
  logic [2:0] asz = 0;
  logic [12:0] aad = 0;
  logic [31:0] awd = 0;
  logic [10:0] bad = 0;
  logic cv = 0, cwe = 0, cbv = 0;
  logic [2:0] csz = 0;
  logic [12:0] cad = 0;
  logic [63:0] cwd = 0;
  logic [9:0] cbad = 0;
  logic r0_v, r0_f, r0_bv, r1_v, r1_f, r1_bv, c_v, c_f, c_bv;
  logic [31:0] r0_d, r0_bd, r1_d, r1_bd;
  logic [63:0] c_d, c_bd;
  int nchk = 0, npass = 0;

  dmem_lsu_ram #(.DATA_W(32), .ADDR_W(13), .OUT_REG(0), .WRITE_FIRST(0)) u0 (
    .clka(clk), .rsta(rst), .a_valid(av), .a_we(awe), .a_size(asz), .a_addr(aad), .a_wdata(awd),
    .a_rsp_valid(r0_v), .a_rdata(r0_d), .a_fault(r0_f),
    .b_valid(bv), .b_addr(bad), .b_rsp_valid(r0_bv), .b_rdata(r0_bd));
  dmem_lsu_ram #(.DATA_W(32), .ADDR_W(13), .OUT_REG(1), .WRITE_FIRST(1)) u1 (
    .clka(clk), .rsta(rst), .a_valid(av), .a_we(awe), .a_size(asz), .a_addr(aad), .a_wdata(awd),
    .a_rsp_valid(r1_v), .a_rdata(r1_d), .a_fault(r1_f),
    .b_valid(bv), .b_addr(bad), .b_rsp_valid(r1_bv), .b_rdata(r1_bd));
  dmem_lsu_ram #(.DATA_W(64), .ADDR_W(13), .OUT_REG(0), .WRITE_FIRST(0)) u2 (
    .clka(clk), .rsta(rst), .a_valid(cv), .a_we(cwe), .a_size(csz), .a_addr(cad), .a_wdata(cwd),
    .a_rsp_valid(c_v), .a_rdata(c_d), .a_fault(c_f),
    .b_valid(cbv), .b_addr(cbad), .b_rsp_valid(c_bv), .b_rdata(c_bd));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask

  task automatic op32(input string tag, input logic we, input logic [2:0] sz, input logic [12:0] ad,
                      input logic [31:0] wd, input logic [31:0] ex, input logic ef);
    @(negedge clk);
    av = 1; awe = we; asz = sz; aad = ad; awd = wd;
    @(negedge clk);
    av = 0;
    chk({tag, " v0"}, r0_v, 1);
    chk({tag, " d0"}, r0_d, ex);
    chk({tag, " f0"}, r0_f, ef);
    chk({tag, " v1 early"}, r1_v, 0);
    @(negedge clk);
    chk({tag, " v1"}, r1_v, 1);
    chk({tag, " d1"}, r1_d, ex);
    chk({tag, " f1"}, r1_f, ef);
    chk({tag, " v0 idle"}, r0_v, 0);
    chk({tag, " f0 idle"}, r0_f, 0);
    chk({tag, " d0 hold"}, r0_d, ex);
  endtask

  task automatic coll(input string tag, input logic [2:0] sz, input logic [12:0] ad, input logic [31:0] wd,
                      input logic [10:0] ba, input logic [31:0] bold, input logic [31:0] bnew);
    @(negedge clk);
    av = 1; awe = 1; asz = sz; aad = ad; awd = wd; bv = 1; bad = ba;
    @(negedge clk);
    av = 0; bv = 0;
    chk({tag, " b0 v"}, r0_bv, 1);
    chk({tag, " b0 d"}, r0_bd, bold);
    chk({tag, " b1 early"}, r1_bv, 0);
    @(negedge clk);
    chk({tag, " b1 v"}, r1_bv, 1);
    chk({tag, " b1 d"}, r1_bd, bnew);
    chk({tag, " b0 hold"}, r0_bd, bold);
  endtask

  task automatic op64(input string tag, input logic we, input logic [2:0] sz, input logic [12:0] ad,
                      input logic [63:0] wd, input logic [63:0] ex, input logic ef);
    @(negedge clk);
    cv = 1; cwe = we; csz = sz; cad = ad; cwd = wd;
    @(negedge clk);
    cv = 0;
    chk({tag, " v"}, c_v, 1);
    chk({tag, " d"}, c_d, ex);
    chk({tag, " f"}, c_f, ef);
    @(negedge clk);
    chk({tag, " idle"}, c_v, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst r0 v", r0_v, 0);
    chk("rst r0 d", r0_d, 0);
    chk("rst r0 f", r0_f, 0);
    chk("rst r0 bv", r0_bv, 0);
    chk("rst r0 bd", r0_bd, 0);
    chk("rst r1 v", r1_v, 0);
    chk("rst r1 d", r1_d, 0);
    chk("rst r1 bd", r1_bd, 0);
    chk("rst c v", c_v, 0);
    chk("rst c d", c_d, 0);
    rst = 0;
    op32("SW 10", 1, 3'b010, 13'h10, 32'hDEADBEEF, 32'h0, 0);
    op32("LW 10", 0, 3'b010, 13'h10, 32'h0, 32'hDEADBEEF, 0);
    op32("SW 20", 1, 3'b010, 13'h20, 32'h44332211, 32'h0, 0);
    op32("SB 21", 1, 3'b000, 13'h21, 32'hFFFFFF80, 32'h0, 0);
    op32("LB 21", 0, 3'b000, 13'h21, 32'h0, 32'hFFFFFF80, 0);
    op32("LBU 21", 0, 3'b100, 13'h21, 32'h0, 32'h00000080, 0);
    op32("LW 20 sb", 0, 3'b010, 13'h20, 32'h0, 32'h44338011, 0);
    op32("SH 22", 1, 3'b001, 13'h22, 32'h00008001, 32'h0, 0);
    op32("LH 22", 0, 3'b001, 13'h22, 32'h0, 32'hFFFF8001, 0);
    op32("LHU 22", 0, 3'b101, 13'h22, 32'h0, 32'h00008001, 0);
    op32("LB 20", 0, 3'b000, 13'h20, 32'h0, 32'h00000011, 0);
    op32("LW 20 sh", 0, 3'b010, 13'h20, 32'h0, 32'h80018011, 0);
    op32("SW 13 mis", 1, 3'b010, 13'h13, 32'h12345678, 32'h0, 1);
    op32("LW 10 keep", 0, 3'b010, 13'h10, 32'h0, 32'hDEADBEEF, 0);
    op32("LH 11 mis", 0, 3'b001, 13'h11, 32'h0, 32'h0, 1);
    op32("LD 32b", 0, 3'b011, 13'h10, 32'h0, 32'h0, 1);
    op32("LWU 32b", 0, 3'b110, 13'h10, 32'h0, 32'h0, 1);
    op32("S sz7", 1, 3'b111, 13'h10, 32'h55555555, 32'h0, 1);
    op32("LW 10 keep2", 0, 3'b010, 13'h10, 32'h0, 32'hDEADBEEF, 0);
    op32("SW 14", 1, 3'b010, 13'h14, 32'hAAAAAAAA, 32'h0, 0);
    coll("coll SW", 3'b010, 13'h14, 32'h11223344, 11'd5, 32'hAAAAAAAA, 32'h11223344);
    coll("coll SB", 3'b000, 13'h15, 32'hFFFFFF55, 11'd5, 32'h11223344, 32'h11225544);
    coll("no coll", 3'b010, 13'h18, 32'h99999999, 11'd5, 32'h11225544, 32'h11225544);
    op32("LW 14", 0, 3'b010, 13'h14, 32'h0, 32'h11225544, 0);
    @(negedge clk);
    av = 1; awe = 1; asz = 3'b010; aad = 13'h30; awd = 32'h5A5A5A5A;
    @(negedge clk);
    awe = 0; aad = 13'h30;
    chk("b2b r0 SW v", r0_v, 1);
    chk("b2b r0 SW d", r0_d, 0);
    chk("b2b r1 early", r1_v, 0);
    @(negedge clk);
    aad = 13'h10;
    chk("b2b r0 LW30", r0_d, 32'h5A5A5A5A);
    chk("b2b r1 SW v", r1_v, 1);
    chk("b2b r1 SW d", r1_d, 0);
    @(negedge clk);
    av = 0;
    chk("b2b r0 LW10 v", r0_v, 1);
    chk("b2b r0 LW10", r0_d, 32'hDEADBEEF);
    chk("b2b r1 LW30", r1_d, 32'h5A5A5A5A);
    @(negedge clk);
    chk("b2b r0 end", r0_v, 0);
    chk("b2b r1 LW10 v", r1_v, 1);
    chk("b2b r1 LW10", r1_d, 32'hDEADBEEF);
    @(negedge clk);
    av = 1; awe = 0; asz = 3'b010; aad = 13'h20;
    @(negedge clk);
    av = 0;
    chk("rmf r1 early", r1_v, 0);
    #2 rst = 1;
    #1;
    chk("rmf r1 v", r1_v, 0);
    chk("rmf r1 d", r1_d, 0);
    chk("rmf r1 f", r1_f, 0);
    chk("rmf r0 v", r0_v, 0);
    chk("rmf r0 d", r0_d, 0);
    chk("rmf r0 bd", r0_bd, 0);
    chk("rmf r1 bd", r1_bd, 0);
    @(negedge clk);
    chk("rmf r1 dropped", r1_v, 0);
    rst = 0;
    @(negedge clk);
    chk("rmf r1 quiet", r1_v, 0);
    op32("LW 20 post", 0, 3'b010, 13'h20, 32'h0, 32'h80018011, 0);
    op64("SD 8", 1, 3'b011, 13'h8, 64'h0123456789ABCDEF, 64'h0, 0);
    op64("LWU C", 0, 3'b110, 13'hC, 64'h0, 64'h0000000001234567, 0);
    op64("LD 8", 0, 3'b011, 13'h8, 64'h0, 64'h0123456789ABCDEF, 0);
    op64("LD 4 mis", 0, 3'b011, 13'h4, 64'h0, 64'h0, 1);
    op64("LH A", 0, 3'b001, 13'hA, 64'h0, 64'hFFFFFFFFFFFF89AB, 0);
    op64("LW 8", 0, 3'b010, 13'h8, 64'h0, 64'hFFFFFFFF89ABCDEF, 0);
    op64("LWU 8", 0, 3'b110, 13'h8, 64'h0, 64'h0000000089ABCDEF, 0);
    op64("LB F", 0, 3'b000, 13'hF, 64'h0, 64'h0000000000000001, 0);
    op64("LW 6 mis", 0, 3'b010, 13'h6, 64'h0, 64'h0, 1);
    op64("SW C", 1, 3'b010, 13'hC, 64'h00000000CAFEBABE, 64'h0, 0);
    op64("LD 8 sw", 0, 3'b011, 13'h8, 64'h0, 64'hCAFEBABE89ABCDEF, 0);
    chk("c b idle v", c_bv, 0);
    chk("c b idle d", c_bd, 0);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
